// File: rtl/seg_display_decoder.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus: debounces and decodes
// each strobed digit back to BCD/binary and measures lit/dark phase durations.
module seg_display_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int DARK_CYCLES   = 16,
   parameter int CNT_W         = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       led_seg,
   input  logic             a1,
   input  logic             a2,
   input  logic             a3,
   input  logic             a4,
   output logic [3:0]       dig1,
   output logic [3:0]       dig2,
   output logic [3:0]       dig3,
   output logic [3:0]       dig4,
   output logic [3:0]       blank,
   output logic             valid,
   output logic [13:0]      value,
   output logic             upd,
   output logic             err,
   output logic             lit,
   output logic [CNT_W-1:0] on_len,
   output logic [CNT_W-1:0] off_len,
   output logic             flash_evt
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int DW = $clog2(DARK_CYCLES + 1);
   localparam logic [SW-1:0]    STAB_MAX  = SW'(STABLE_CYCLES);
   localparam logic [SW-1:0]    STAB_HIT  = SW'(STABLE_CYCLES - 1);
   localparam logic [DW-1:0]    DARK_LAST = DW'(DARK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] DARK_LEN  = CNT_W'(DARK_CYCLES);
   localparam logic [6:0]       SEG_BLANK = 7'h7F;

   typedef enum logic {DARK = 1'b0, LIT = 1'b1} lit_state_t;

   // Returns {legal, bcd}; legal is 0 for blank and unknown patterns.
   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      logic [4:0] r;
      r = 5'h00;
      case (s)
         7'h40: r = {1'b1, 4'd0};
         7'h79: r = {1'b1, 4'd1};
         7'h24: r = {1'b1, 4'd2};
         7'h30: r = {1'b1, 4'd3};
         7'h19: r = {1'b1, 4'd4};
         7'h12: r = {1'b1, 4'd5};
         7'h02: r = {1'b1, 4'd6};
         7'h78: r = {1'b1, 4'd7};
         7'h00: r = {1'b1, 4'd8};
         7'h10: r = {1'b1, 4'd9};
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   logic [3:0]  an_low;
   logic        sel;
   logic [1:0]  pos;
   logic        multi;
   logic        prev_sel;
   logic [1:0]  prev_pos;
   logic [6:0]  prev_seg;
   logic [SW-1:0] stab_cnt;
   logic [SW-1:0] stab_nxt;
   logic        same;
   logic        commit;
   logic [4:0]  dec;
   logic        is_blank;
   logic        chg;
   logic        bad;
   logic        chg_q;
   logic [3:0]  dig_q [4];
   logic [3:0]  blank_q;
   logic [3:0]  committed;
   logic [13:0] val_calc;
   logic [13:0] v [4];

   assign an_low = ~{a4, a3, a2, a1};

   always_comb begin
      sel   = 1'b0;
      pos   = 2'd0;
      multi = 1'b0;
      case (an_low)
         4'b0000: sel = 1'b0;
         4'b0001: begin sel = 1'b1; pos = 2'd0; end
         4'b0010: begin sel = 1'b1; pos = 2'd1; end
         4'b0100: begin sel = 1'b1; pos = 2'd2; end
         4'b1000: begin sel = 1'b1; pos = 2'd3; end
         default: multi = 1'b1;
      endcase
   end

   // The run counter saturates at STABLE_CYCLES so a held digit commits only once.
   always_comb begin
      same = sel && prev_sel && (pos == prev_pos) && (led_seg == prev_seg);
      if (!sel)                   stab_nxt = '0;
      else if (!same)             stab_nxt = SW'(1);
      else if (stab_cnt == STAB_MAX) stab_nxt = STAB_MAX;
      else                        stab_nxt = stab_cnt + SW'(1);
      commit = same && (stab_cnt == STAB_HIT);
   end

   always_comb begin
      dec      = seg_decode(led_seg);
      is_blank = (led_seg == SEG_BLANK);
      chg      = 1'b0;
      bad      = 1'b0;
      if (commit) begin
         if (dec[4])        chg = blank_q[pos] || (dig_q[pos] != dec[3:0]);
         else if (is_blank) chg = !blank_q[pos];
         else               bad = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) v[i] = blank_q[i] ? 14'd0 : {10'd0, dig_q[i]};
      val_calc = v[0] * 14'd1000 + v[1] * 14'd100 + v[2] * 14'd10 + v[3];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_sel  <= 1'b0;
         prev_pos  <= 2'd0;
         prev_seg  <= 7'h00;
         stab_cnt  <= '0;
         for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
         blank_q   <= 4'hF;
         committed <= 4'h0;
         chg_q     <= 1'b0;
         upd       <= 1'b0;
         err       <= 1'b0;
         value     <= 14'd0;
      end else begin
         prev_sel <= sel;
         prev_pos <= pos;
         prev_seg <= led_seg;
         stab_cnt <= stab_nxt;
         if (commit) begin
            committed[pos] <= 1'b1;
            if (dec[4]) begin
               dig_q[pos]   <= dec[3:0];
               blank_q[pos] <= 1'b0;
            end else if (is_blank) begin
               blank_q[pos] <= 1'b1;
            end
         end
         chg_q <= chg;
         upd   <= chg_q;
         err   <= err | multi | bad;
         value <= val_calc;
      end
   end

   assign dig1  = dig_q[0];
   assign dig2  = dig_q[1];
   assign dig3  = dig_q[2];
   assign dig4  = dig_q[3];
   assign blank = blank_q;
   assign valid = &committed;

   lit_state_t    state;
   lit_state_t    state_nxt;
   logic [DW-1:0] dark_run;
   logic [DW-1:0] dark_nxt;
   logic          lit_cyc;
   logic          go_lit;
   logic          go_dark;
   logic [CNT_W-1:0] on_cnt;
   logic [CNT_W-1:0] off_cnt;
   logic [CNT_W-1:0] on_hold;
   logic [CNT_W-1:0] on_inc;
   logic [CNT_W-1:0] off_inc;
   logic          seen_lit;

   assign lit_cyc = sel && (led_seg != SEG_BLANK);

   always_comb begin
      state_nxt = state;
      dark_nxt  = dark_run;
      go_lit    = 1'b0;
      go_dark   = 1'b0;
      case (state)
         DARK: begin
            if (lit_cyc) begin
               state_nxt = LIT;
               go_lit    = 1'b1;
               dark_nxt  = '0;
            end
         end
         LIT: begin
            if (lit_cyc) begin
               dark_nxt = '0;
            end else if (dark_run == DARK_LAST) begin
               state_nxt = DARK;
               go_dark   = 1'b1;
               dark_nxt  = '0;
            end else begin
               dark_nxt = dark_run + DW'(1);
            end
         end
         default: state_nxt = DARK;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= DARK;
         dark_run <= '0;
      end else begin
         state    <= state_nxt;
         dark_run <= dark_nxt;
      end
   end

   assign lit     = (state == LIT);
   assign on_inc  = (on_cnt == CNT_MAX) ? on_cnt : on_cnt + CNT_W'(1);
   assign off_inc = (off_cnt == CNT_MAX) ? off_cnt : off_cnt + CNT_W'(1);

   // The lit cycle that wakes the display belongs to the new on phase; the
   // qualifying dark run is handed from the on phase to the off phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         on_cnt    <= '0;
         off_cnt   <= '0;
         on_hold   <= '0;
         on_len    <= '0;
         off_len   <= '0;
         flash_evt <= 1'b0;
         seen_lit  <= 1'b0;
      end else begin
         flash_evt <= 1'b0;
         if (go_lit) begin
            on_cnt   <= CNT_W'(1);
            off_cnt  <= '0;
            seen_lit <= 1'b1;
            if (seen_lit) begin
               on_len    <= on_hold;
               off_len   <= off_cnt;
               flash_evt <= 1'b1;
            end
         end else if (state == LIT) begin
            if (go_dark) begin
               on_hold <= on_inc - DARK_LEN;
               on_cnt  <= '0;
               off_cnt <= DARK_LEN;
            end else begin
               on_cnt <= on_inc;
            end
         end else begin
            off_cnt <= off_inc;
         end
      end
   end

endmodule

// File: tb/tb_seg_display_decoder.sv
// Bench for seg_display_decoder: randomized and directed display traffic checked against
// a digit/phase-level reference model through update and flash-event scoreboards.
module tb_seg_display_decoder;
  localparam int S  = 4;
  localparam int D  = 16;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [6:0]    led_seg = 7'h7F;
  logic          a1 = 1'b1, a2 = 1'b1, a3 = 1'b1, a4 = 1'b1;
  logic [3:0]    dig1, dig2, dig3, dig4, blank;
  logic          valid, upd, err, lit, flash_evt;
  logic [13:0]   value;
  logic [CW-1:0] on_len, off_len;

  seg_display_decoder #(.STABLE_CYCLES(S), .DARK_CYCLES(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .led_seg(led_seg),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
    .blank(blank), .valid(valid), .value(value), .upd(upd), .err(err),
    .lit(lit), .on_len(on_len), .off_len(off_len), .flash_evt(flash_evt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Expected update record {dig1,dig2,dig3,dig4,blank,value}; flash record {on_len,off_len}.
  logic [33:0]     upd_q[$];
  logic [2*CW-1:0] flash_q[$];

  // Reference model state
  int         m_dig [4];
  logic [3:0] m_blank;
  logic [3:0] m_comm;
  bit         m_err;
  bit         m_lit;
  int         run_len;
  int         prev_key;
  int         dark_run;
  int         cyc;
  int         on_start;
  int         off_start;
  bit         seen_lit;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int model_value();
    int v = 0;
    for (int p = 0; p < 4; p++) v = v * 10 + (m_blank[p] ? 0 : m_dig[p]);
    return v;
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < 4; p++) m_dig[p] = 0;
    m_blank = 4'hF; m_comm = 4'h0; m_err = 1'b0; m_lit = 1'b0;
    run_len = 0; prev_key = -1; dark_run = 0; cyc = 0;
    on_start = 0; off_start = 0; seen_lit = 1'b0;
  endfunction

  function automatic void model_commit(input int p, input logic [6:0] seg);
    int idx = -1;
    bit chg = 1'b0;
    for (int k = 0; k < 10; k++) if (seg_tab[k] == seg) idx = k;
    if (idx >= 0) begin
      chg = m_blank[p] || (m_dig[p] != idx);
      m_dig[p] = idx;
      m_blank[p] = 1'b0;
    end else if (seg == 7'h7F) begin
      chg = !m_blank[p];
      m_blank[p] = 1'b1;
    end else begin
      m_err = 1'b1;
    end
    m_comm[p] = 1'b1;
    if (chg)
      upd_q.push_back({4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3]),
                       m_blank, 14'(model_value())});
  endfunction

  // p = -1 means nothing selected this cycle.
  function automatic void model_step(input int p, input bit two_low, input logic [6:0] seg);
    int key;
    bit lc;
    if (two_low) m_err = 1'b1;
    key = (p < 0) ? -1 : p * 128 + int'(seg);
    if (key < 0)             run_len = 0;
    else if (key == prev_key) run_len++;
    else                     run_len = 1;
    prev_key = key;
    if (run_len == S) model_commit(p, seg);

    lc = (p >= 0) && (seg != 7'h7F);
    if (!m_lit) begin
      if (lc) begin
        m_lit = 1'b1;
        dark_run = 0;
        if (seen_lit)
          flash_q.push_back({CW'(off_start - on_start), CW'(cyc - off_start)});
        seen_lit = 1'b1;
        on_start = cyc;
      end
    end else if (lc) begin
      dark_run = 0;
    end else begin
      dark_run++;
      if (dark_run == D) begin
        m_lit = 1'b0;
        off_start = cyc - D + 1;
      end
    end
    cyc++;
  endfunction

  task automatic check_state();
    check("state", {41'd0, lit, err, valid, blank, dig1, dig2, dig3, dig4},
          {41'd0, m_lit, m_err, &m_comm, m_blank,
           4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])});
  endtask

  // Called at a falling edge; drives one cycle and checks the registered result.
  task automatic drive_cycle(input int p, input bit two_low, input logic [6:0] seg);
    a1 = 1'b1; a2 = 1'b1; a3 = 1'b1; a4 = 1'b1;
    if (two_low) begin
      a1 = 1'b0; a2 = 1'b0;
    end else begin
      case (p)
        0: a1 = 1'b0;
        1: a2 = 1'b0;
        2: a3 = 1'b0;
        3: a4 = 1'b0;
        default: ;
      endcase
    end
    led_seg = seg;
    @(posedge clk);
    model_step(two_low ? -1 : p, two_low, seg);
    @(negedge clk);
    check_state();
  endtask

  task automatic strobe(input int p, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) drive_cycle(p, 1'b0, seg);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(-1, 1'b0, 7'h7F);
  endtask

  task automatic show(input int d0, input int d1, input int d2, input int d3,
                      input int rounds, input int hold);
    int ds [4];
    ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
    for (int r = 0; r < rounds; r++)
      for (int p = 0; p < 4; p++) strobe(p, seg_tab[ds[p]], hold);
  endtask

  task automatic do_reset();
    check("upd_pending", 64'(upd_q.size()), 64'd0);
    check("flash_pending", 64'(flash_q.size()), 64'd0);
    a1 = 1'b1; a2 = 1'b1; a3 = 1'b1; a4 = 1'b1;
    led_seg = 7'h7F;
    #2;
    rst = 1'b1;
    #1;
    check("rst_dig", {48'd0, dig1, dig2, dig3, dig4}, 64'd0);
    check("rst_blank", {60'd0, blank}, 64'hF);
    check("rst_flags", {59'd0, valid, upd, err, lit, flash_evt}, 64'd0);
    check("rst_value", {50'd0, value}, 64'd0);
    check("rst_len", {16'd0, on_len, off_len}, 64'd0);
    model_reset();
    upd_q.delete();
    flash_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    started = 1'b1;
  endtask

  always @(negedge clk) begin
    if (started && rst === 1'b0) begin
      if (upd === 1'b1) begin
        if (upd_q.size() == 0) begin
          check("upd_unexpected", 64'd1, 64'd0);
        end else begin
          logic [33:0] e;
          e = upd_q.pop_front();
          check("upd_record", {30'd0, dig1, dig2, dig3, dig4, blank, value}, {30'd0, e});
        end
      end
      if (flash_evt === 1'b1) begin
        if (flash_q.size() == 0) begin
          check("flash_unexpected", 64'd1, 64'd0);
        end else begin
          logic [2*CW-1:0] f;
          f = flash_q.pop_front();
          check("flash_record", {16'd0, on_len, off_len}, {16'd0, f});
        end
      end
    end
  end

  initial begin
    int p;
    int r;
    int hold;
    int gap;
    logic [6:0] s;
    model_reset();
    @(negedge clk);
    do_reset();

    // Round-robin 2015
    strobe(0, 7'h24, 8);
    strobe(1, 7'h40, 8);
    strobe(2, 7'h79, 8);
    strobe(3, 7'h12, 8);
    check("rr_digits", {48'd0, dig1, dig2, dig3, dig4}, {48'd0, 4'd2, 4'd0, 4'd1, 4'd5});
    check("rr_value", {50'd0, value}, 64'd2015);
    check("rr_valid", {63'd0, valid}, 64'd1);

    // Short run of 3 must not commit; 9 commits after its own stable run
    strobe(3, 7'h30, S - 1);
    check("short_run_held", {60'd0, dig4}, 64'd5);
    strobe(3, 7'h10, 8);
    check("long_run_dig4", {60'd0, dig4}, 64'd9);

    // 5-cycle gaps keep the display lit
    for (int k = 0; k < 3; k++)
      for (int q = 0; q < 4; q++) begin
        strobe(q, seg_tab[(k + q) % 10], 6);
        idle(5);
      end
    check("gap_lit", {63'd0, lit}, 64'd1);

    // Random legal traffic with occasional blanks and long dark gaps
    for (int i = 0; i < 150; i++) begin
      p = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      s = (r < 8) ? seg_tab[$urandom_range(0, 9)] : 7'h7F;
      hold = $urandom_range(1, 9);
      gap = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 3) : $urandom_range(10, 24);
      strobe(p, s, hold);
      idle(gap);
    end
    check("rand_err_clear", {63'd0, err}, 64'd0);

    // Two anodes low together: sticky error through later legal traffic
    drive_cycle(-1, 1'b1, 7'h24);
    show(1, 2, 3, 4, 2, 6);
    check("multi_err_sticky", {63'd0, err}, 64'd1);

    do_reset();
    strobe(1, 7'h55, 6);
    show(4, 3, 2, 1, 1, 6);
    check("pattern_err_sticky", {63'd0, err}, 64'd1);
    check("pattern_dig2_kept", {60'd0, dig2}, 64'd3);

    // Flash measurement on 0150
    do_reset();
    show(0, 1, 5, 0, 25, 10);
    idle(1000);
    show(0, 1, 5, 0, 25, 10);
    check("flash_on_len", {40'd0, on_len}, 64'd1000);
    check("flash_off_len", {40'd0, off_len}, 64'd1000);
    idle(1000);
    show(0, 1, 5, 0, 2, 10);
    check("value_0150", {50'd0, value}, 64'd150);

    // Reset in the middle of a partially debounced digit while showing 9999
    show(9, 9, 9, 9, 3, 8);
    strobe(0, 7'h79, 2);
    do_reset();
    strobe(0, 7'h79, S - 1);
    idle(4);
    check("post_rst_blank", {60'd0, blank}, 64'hF);

    check("upd_q_empty", 64'(upd_q.size()), 64'd0);
    check("flash_q_empty", 64'(flash_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_display_decoder.md
# seg_display_decoder

Receive-side decoder for the parking meter's multiplexed 4-digit seven-segment output. It samples `led_seg` and the four anode strobes, de-multiplexes and debounces each digit, and decodes the segment patterns back to BCD and a binary seconds value. It also measures the lit/dark durations of the display so that flash behaviour can be checked. It sits on the display bus as a self-checking monitor for bench and on-board readback.

## Interface
Parameters:
- `STABLE_CYCLES`, 4: consecutive identical samples required to commit a digit (≥2).
- `DARK_CYCLES`, 16: consecutive dark cycles required to declare the display dark.
- `CNT_W`, 24: width of the on/off duration counters.

Ports:
- `clk` in 1: system clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `led_seg` in 7: segments, active-low, `[6:0]={g,f,e,d,c,b,a}`.
- `a1`,`a2`,`a3`,`a4` in 1 each: anode enables, active-low; `a1` = thousands, `a4` = units.
- `dig1`..`dig4` out 4 each: decoded BCD digit per position.
- `blank` out 4: per-position blank flag; `[0]` is `dig1`.
- `valid` out 1: every position has committed at least once since reset.
- `value` out 14: dig1·1000 + dig2·100 + dig3·10 + dig4; blank positions count as 0.
- `upd` out 1: one-cycle pulse when a committed digit or blank flag changes.
- `err` out 1: sticky protocol or pattern error; cleared only by `rst`.
- `lit` out 1: current display state (1 = lit, 0 = dark).
- `on_len`, `off_len` out CNT_W each: durations of the last complete lit and dark phases, in cycles.
- `flash_evt` out 1: one-cycle pulse when `on_len`/`off_len` are updated.

## Operation
- Anode decode each cycle:
  - Exactly one anode low → sample = {position, `led_seg`}.
  - All anodes high → no-select.
  - Two or more low → set `err`; the cycle counts as no-select.
- Debounce:
  - A sample identical to the previous cycle's sample increments `stab_cnt`. Any other sample, or no-select, reloads `stab_cnt` to 1 (or 0 for no-select).
  - When `stab_cnt` reaches `STABLE_CYCLES`, commit exactly once per run.
- Segment decode table (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, 7F=blank.
- Commit actions:
  - Legal digit → `dig_n`=value, `blank[n]`=0.
  - 7F → `blank[n]`=1, `dig_n` held.
  - Any other pattern → set `err`; position unchanged but still marked committed.
- `upd` asserts in the commit cycle+1 if `dig_n` or `blank[n]` changed.
- `value` is registered and updated in the cycle after any commit. Range is 0–9999, so it never overflows 14 bits.
- Lit/dark state machine (states LIT and DARK; resets to DARK):
  - Lit cycle: one anode active and `led_seg`≠7F. Dark cycle: anything else.
  - DARK→LIT on the first lit cycle.
  - LIT→DARK after `DARK_CYCLES` consecutive dark cycles. Short gaps between digit strobes therefore do not end a lit phase.
- Duration counters:
  - `on_cnt` counts every cycle spent in LIT, including dark cycles that do not complete a `DARK_CYCLES` run.
  - `off_cnt` counts DARK cycles plus the `DARK_CYCLES` qualification cycles, which are moved from `on_cnt` at the transition.
  - Both counters saturate at 2^CNT_W−1.
- Flash measurement:
  - On LIT→DARK, latch `on_cnt` internally.
  - On DARK→LIT, `on_len`←latched value, `off_len`←`off_cnt`, and `flash_evt` pulses. Both counters then restart.
  - `flash_evt` is suppressed for the first DARK→LIT after reset, because no complete phase pair exists yet.

## Timing
- Reset values: `dig1`..`dig4`=0, `blank`=4'hF, `valid`=0, `value`=0, `upd`=0, `err`=0, `lit`=0, `on_len`=`off_len`=0, `flash_evt`=0.
- `rst` mid-operation clears all state immediately, including any partially debounced digit.
- Commit latency: `dig_n` and `blank` update `STABLE_CYCLES` cycles after the first cycle of a stable run. `upd` and `value` follow 1 cycle later.
- `lit` rises 1 cycle after the first lit cycle. It falls 1 cycle after the `DARK_CYCLES`-th dark cycle.
- Simultaneous commit and lit transition: both take effect independently in the same cycle.
- `err` takes priority over nothing; decode continues after an error.

## Test plan
- Reset, then strobe `a1`..`a4` round-robin, 8 cycles each, with patterns 24,40,79,12 → `dig`=2,0,1,5, `value`=2015, `valid`=1, `upd` pulses 4 times.
- Hold digit 3 on `a4` for only `STABLE_CYCLES`−1 cycles, then switch to 9 → no commit of 3; 9 commits after 4 stable cycles.
- Drive `a1`&`a2` low together, and separately pattern 7'h55 → `err`=1 and held through later legal traffic until `rst`.
- Display 0150 lit for 1000 cycles, dark for 1000, lit for 1000, dark for 1000, lit → first DARK→LIT no event; second `flash_evt` with `on_len`=1000, `off_len`=1000.
- Insert 5-cycle gaps between strobes (<`DARK_CYCLES`) → `lit` stays 1 and no `flash_evt`.
- Assert `rst` mid-run while showing 9999 → all outputs return to reset values the same cycle; `blank`=4'hF.
